// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: picks one of RUN/BUBBLE/FREEZE/REDIRECT per cycle and drives
// the stage-register write/flush controls, plus stall/flush counters and a freeze watchdog.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1_addr,
   input  logic [4:0]       ID_rs2_addr,
   input  logic             ID_uses_rs1,
   input  logic             ID_uses_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rd_addr,
   input  logic             EX_branch_taken,
   input  logic             IM_wait,
   input  logic             DM_wait,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Write,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Write,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StBubble   = 2'd1,
      StFreeze   = 2'd2,
      StRedirect = 2'd3
   } act_e;

   localparam logic [15:0] TimeoutMax = 16'(TIMEOUT);
   localparam logic [15:0] TimeoutHit = 16'(TIMEOUT - 1);

   act_e             state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic             load_use;

   always_comb begin
      load_use = EX_MemRead && (EX_rd_addr != 5'd0) &&
                 ((ID_uses_rs1 && (ID_rs1_addr == EX_rd_addr)) ||
                  (ID_uses_rs2 && (ID_rs2_addr == EX_rd_addr)));

      if (IM_wait || DM_wait) begin
         state_d = StFreeze;
      end else if (EX_branch_taken) begin
         state_d = StRedirect;
      end else if (load_use) begin
         state_d = StBubble;
      end else begin
         state_d = StRun;
      end
   end

   always_comb begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Write  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      // Controls are forced quiet for the whole reset cycle.
      if (!rst) begin
         unique case (state_d)
            StRun: begin
               PCWrite      = 1'b1;
               IF_ID_Write  = 1'b1;
               ID_EX_Write  = 1'b1;
               EX_MEM_Write = 1'b1;
               MEM_WB_Write = 1'b1;
            end
            StBubble: begin
               ID_EX_Write  = 1'b1;
               ID_EX_Flush  = 1'b1;
               EX_MEM_Write = 1'b1;
               MEM_WB_Write = 1'b1;
            end
            StRedirect: begin
               PCWrite      = 1'b1;
               IF_ID_Write  = 1'b1;
               IF_ID_Flush  = 1'b1;
               ID_EX_Write  = 1'b1;
               ID_EX_Flush  = 1'b1;
               EX_MEM_Write = 1'b1;
               MEM_WB_Write = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = 16'd0;
      timeout_err_d = timeout_err_q;
      if ((state_d == StBubble) || (state_d == StFreeze)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (state_d == StRedirect) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (state_d == StFreeze) begin
         wait_cnt_d = (wait_cnt_q >= TimeoutMax) ? TimeoutMax : wait_cnt_q + 16'd1;
         if (wait_cnt_q >= TimeoutHit) begin
            timeout_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         wait_cnt_q    <= 16'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Per-cycle sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC.
- Generates write-enable (hold) and flush (bubble) controls from four events: load-use hazards, taken branches/jumps resolved in EX, and instruction- or data-memory wait.
- Keeps stall/flush performance counters and a freeze watchdog.
- Sits beside the datapath in the CPU top; drives the IF/ID register's IF_ID_Write and Flush inputs directly.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.
- TIMEOUT, 1023, consecutive freeze cycles before timeout_err sets; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ID_rs1_addr  in  5  rs1 index of the instruction in ID.
- ID_rs2_addr  in  5  rs2 index of the instruction in ID.
- ID_uses_rs1  in  1  ID instruction reads rs1.
- ID_uses_rs2  in  1  ID instruction reads rs2.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_rd_addr  in  5  destination of the instruction in EX.
- EX_branch_taken  in  1  EX redirects the PC (taken branch, JAL or JALR).
- IM_wait  in  1  instruction memory not ready this cycle.
- DM_wait  in  1  data memory not ready this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  clear IF/ID to zero.
- ID_EX_Write  out  1  ID/EX load enable.
- ID_EX_Flush  out  1  clear ID/EX to a bubble.
- EX_MEM_Write  out  1  EX/MEM load enable.
- MEM_WB_Write  out  1  MEM/WB load enable.
- state_o  out  2  action taken last cycle: 0 RUN, 1 BUBBLE, 2 FREEZE, 3 REDIRECT.
- stall_cnt  out  CNT_W  count of BUBBLE and FREEZE cycles.
- flush_cnt  out  CNT_W  count of REDIRECT cycles.
- timeout_err  out  1  sticky watchdog error.

Behaviour:

Reset:
- rst is sampled on the clk edge.
- Reset values: state = RUN, stall_cnt = 0, flush_cnt = 0, wait_cnt = 0, timeout_err = 0.
- While rst is high, all control outputs are 0 (all *_Write = 0, all *_Flush = 0).
- Reset mid-freeze or mid-bubble aborts the action; the first cycle after reset evaluates from RUN.

Control outputs:
- Combinational from the current inputs.
- Exactly one action per cycle, chosen by priority:

1. FREEZE, when IM_wait or DM_wait is 1:
   - All *_Write = 0, all *_Flush = 0.
   - EX_branch_taken and load-use are ignored; EX is held, so they are re-evaluated once the freeze ends.
2. REDIRECT, when EX_branch_taken is 1:
   - PCWrite = 1, IF_ID_Flush = 1, ID_EX_Flush = 1.
   - All *_Write = 1.
   - Load-use is ignored, because the ID instruction is discarded.
3. BUBBLE, when load_use is true:
   - load_use = EX_MemRead, and EX_rd_addr != 0, and either (ID_uses_rs1 and ID_rs1_addr == EX_rd_addr) or (ID_uses_rs2 and ID_rs2_addr == EX_rd_addr).
   - PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1.
   - ID_EX_Write, EX_MEM_Write and MEM_WB_Write = 1.
   - IF_ID_Flush = 0.
4. RUN, otherwise:
   - All *_Write = 1, all *_Flush = 0.

Flush versus write:
- A stage register gives its flush priority over its write enable.
- The ctrl therefore asserts *_Write = 1 alongside a flush only in REDIRECT and BUBBLE.

Registered state (updates on every non-reset edge):
- state is set to the action taken this cycle; state_o = state.
- A load-use hazard resolves after one BUBBLE, because the load moves to MEM. Back-to-back BUBBLE only occurs on a new hazard.

Counters:
- stall_cnt increments by 1 in each BUBBLE or FREEZE cycle.
- flush_cnt increments by 1 in each REDIRECT cycle.
- Both wrap modulo 2^CNT_W with no saturation.

Watchdog:
- wait_cnt (16 bits) increments in each FREEZE cycle and clears to 0 in any non-FREEZE cycle.
- When wait_cnt reaches TIMEOUT - 1 during a FREEZE cycle, timeout_err sets on that edge. It stays 1 until rst.
- wait_cnt saturates at TIMEOUT.
- timeout_err does not alter any pipeline control.

Boundary cases:
- rd = x0 never causes a stall.
- Load-use and branch in the same cycle: REDIRECT.
- IM_wait and DM_wait together: a single FREEZE; stall_cnt increments by 1.

Test Plan:
- Reset hold: rst = 1 for 3 cycles with random inputs -> all *_Write and *_Flush = 0; after release, state_o = 0, stall_cnt = 0, flush_cnt = 0, timeout_err = 0.
- Load-use: EX_MemRead = 1, EX_rd_addr = 5, ID_rs2_addr = 5, ID_uses_rs2 = 1 for one cycle -> PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1, EX_MEM_Write = 1; next cycle state_o = 1 and stall_cnt = 1. Repeat with EX_rd_addr = 0, or with ID_uses_rs2 = 0 -> RUN.
- Branch with hazard: EX_branch_taken = 1 together with a load-use match -> IF_ID_Flush = 1, ID_EX_Flush = 1, PCWrite = 1; flush_cnt = 1, stall_cnt unchanged.
- Freeze priority: DM_wait = 1 for 4 cycles with EX_branch_taken = 1 -> all enables 0 and no flushes for 4 cycles, stall_cnt = 4; on the 5th cycle (wait low) REDIRECT occurs, flush_cnt = 1.
- Watchdog: TIMEOUT = 8; IM_wait held for 8 cycles -> timeout_err = 1 after the 8th edge; deassert IM_wait -> timeout_err stays 1 until rst. With 7 cycles only -> timeout_err stays 0.
- Counter wrap: CNT_W = 4, 17 FREEZE cycles -> stall_cnt = 1.
